// File: rtl/ppu_pattern_pkg.sv
// ppu_pattern_pkg
//   Shared types and constants for the PPU test-pattern source.
//   - pattern_mode_e : selectable test patterns
//   - BAR_COLOURS    : 24-bit colour codes of the eight vertical bars, left to right
//   - bar_mask       : reduces a bar colour to one "full-scale" flag per channel,
//                      so the colour scales to any channel width
package ppu_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BORDER = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_GRAD   = 2'd2,
    MODE_FLAT   = 2'd3
  } pattern_mode_e;

  localparam int BAR_COUNT = 8;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_COLOURS [BAR_COUNT] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Bar channels are either full-scale or zero, so one bit per channel
  // ({R,G,B}) is enough to rebuild the colour at any CH_W.
  function automatic logic [2:0] bar_mask(input logic [23:0] colour);
    return {|colour[23:16], |colour[15:8], |colour[7:0]};
  endfunction

endpackage

// File: rtl/ppu_pipe_delay.sv
// ppu_pipe_delay
//   Fixed-depth shift register with synchronous clear. Used to stretch the
//   pattern output pipeline to the configured latency.
// Ports
//   clk_p  in   1      clock
//   rst_p  in   1      synchronous clear, active high (empties every stage)
//   d      in   WIDTH  data in
//   q      out  WIDTH  data in, delayed by DEPTH cycles (DEPTH >= 1)
module ppu_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_p,
  input  logic             rst_p,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the value its neighbour held before the edge; blocking would collapse the
  // shift register into a single stage.
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      // NOTE: this array is cleared on reset on purpose: stale pixels must not
      // leak out after a reset. Plain storage arrays normally stay unreset.
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/ppu_pattern_gen.sv
// ppu_pattern_gen
//   PPU-domain raster timing and test-pattern source feeding hdmi_upscaler.
//   Free-running px/py counters with resync on new_frame, four patterns
//   (border/checker, colour bars, gradient, flat frame-count grey). The pattern
//   mode is latched only on frame events so a frame never tears.
// Optional feature macro
//   PATTERN_SCROLL_EN : scroll the checker and bars horizontally by frame_cnt.
//                       Undefined (default): static patterns, no scroll adder.
// Ports
//   clk_p        in   1       PPU pixel clock
//   rst_p        in   1       synchronous reset, active high
//   new_frame    in   1       resync request; counters read (0,0) next cycle
//   mode_i       in   2       requested pattern (pattern_mode_e)
//   px, py       out  CW      current column / row counters
//   frame_start  out  1       pulse in the cycle px/py enter (0,0) by wrap or resync
//   frame_cnt    out  8       frames started since reset, wraps
//   visible      out  1       rgb_p lies in the visible area (LATENCY delayed)
//   rgb_p        out  3*CH_W  {R,G,B} pattern pixel (LATENCY delayed)
module ppu_pattern_gen
  import ppu_pattern_pkg::*;
#(
  parameter int ISCREEN_WIDTH  = 256,
  parameter int ISCREEN_HEIGHT = 240,
  parameter int IFRAME_WIDTH   = 341,
  parameter int IFRAME_HEIGHT  = 262,
  parameter int CH_W           = 8,
  parameter int LATENCY        = 1,
  parameter int CW             = 9
) (
  input  logic              clk_p,
  input  logic              rst_p,
  input  logic              new_frame,
  input  logic [1:0]        mode_i,
  output logic [CW-1:0]     px,
  output logic [CW-1:0]     py,
  output logic              frame_start,
  output logic [7:0]        frame_cnt,
  output logic              visible,
  output logic [3*CH_W-1:0] rgb_p
);

  localparam int PIX_W = 3 * CH_W;

  localparam logic [CW-1:0] X_LAST  = CW'(IFRAME_WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(IFRAME_HEIGHT - 1);
  localparam logic [CW-1:0] X_VIS   = CW'(ISCREEN_WIDTH);
  localparam logic [CW-1:0] Y_VIS   = CW'(ISCREEN_HEIGHT);
  localparam logic [CW-1:0] X_RIGHT = CW'(ISCREEN_WIDTH - 1);
  localparam logic [CW-1:0] Y_BOT   = CW'(ISCREEN_HEIGHT - 1);

  pattern_mode_e mode_q;
  logic [2:0]    bar_q;

  logic          line_end, frame_end, frame_evt;
  logic [CW-1:0] px_n, py_n;
  logic [7:0]    fc_n;
  logic [2:0]    bar_n, bar_start;
  logic [CW-1:0] xs, xs_inc;

  // Right-hand edge of bar idx, i.e. where bar idx+1 begins. A mux of
  // constants, so no multiplier or divider is built.
  function automatic logic [CW-1:0] bar_edge(input logic [2:0] idx);
    logic [CW-1:0] e;
    e = '0;
    for (int k = 0; k < BAR_COUNT; k++)
      if (idx == 3'(k)) e = CW'((k + 1) * ISCREEN_WIDTH / BAR_COUNT);
    return e;
  endfunction

`ifdef PATTERN_SCROLL_EN
  localparam int SUM_W     = CW + 9;
  localparam int MOD_STEPS = (IFRAME_WIDTH + 255) / ISCREEN_WIDTH + 1;

  // (x + fc) mod ISCREEN_WIDTH via a bounded chain of conditional subtracts.
  function automatic logic [CW-1:0] scroll_x(input logic [CW-1:0] x, input logic [7:0] fc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(x) + SUM_W'(fc);
    for (int i = 0; i < MOD_STEPS; i++)
      if (s >= SUM_W'(ISCREEN_WIDTH)) s = s - SUM_W'(ISCREEN_WIDTH);
    return CW'(s);
  endfunction

  // Bar index for a scrolled column; only needed to seed the bar counter at
  // the start of a line, where the scroll offset makes it non-zero.
  function automatic logic [2:0] bar_of(input logic [CW-1:0] x);
    logic [2:0] b;
    b = '0;
    for (int k = 1; k < BAR_COUNT; k++)
      if (x >= CW'(k * ISCREEN_WIDTH / BAR_COUNT)) b = 3'(k);
    return b;
  endfunction

  assign xs        = scroll_x(px, frame_cnt);
  assign bar_start = bar_of(scroll_x('0, fc_n));
`else
  assign xs        = px;
  assign bar_start = 3'd0;
`endif

  assign xs_inc = xs + CW'(1);

  // Counter and frame-event next state. A resync that lands on the natural
  // wrap is a single event because both simply raise frame_evt.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    line_end  = (px == X_LAST);
    frame_end = line_end && (py == Y_LAST);
    frame_evt = new_frame || frame_end;
    px_n      = px + CW'(1);
    py_n      = py;
    fc_n      = frame_cnt;
    if (frame_evt) begin
      px_n = '0;
      py_n = '0;
      fc_n = frame_cnt + 8'd1;
    end else if (line_end) begin
      px_n = '0;
      py_n = py + CW'(1);
    end
  end

  // Bar index tracks the (possibly scrolled) column: reseeded whenever px
  // returns to 0, wraps when the scrolled column wraps, otherwise steps when
  // the next column reaches the current bar's right edge.
  always_comb begin
    bar_n = bar_q;
    if (frame_evt || line_end)
      bar_n = bar_start;
    else if (xs_inc == X_VIS)
      bar_n = 3'd0;
    else if (bar_q != 3'(BAR_COUNT - 1) && xs_inc == bar_edge(bar_q))
      bar_n = bar_q + 3'd1;
  end

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      px          <= '0;
      py          <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      bar_q       <= '0;
      mode_q      <= MODE_BORDER;
    end else begin
      px          <= px_n;
      py          <= py_n;
      frame_start <= frame_evt;
      frame_cnt   <= fc_n;
      bar_q       <= bar_n;
      if (frame_evt) mode_q <= pattern_mode_e'(mode_i);
    end
  end

  // Pixel function for the coordinate currently on px/py.
  logic [CH_W-1:0]  x_c, xs_c, y_c, flat_c;
  logic [2:0]       bar_m;
  logic             vis_c;
  logic [PIX_W-1:0] rgb_c;

  assign x_c    = CH_W'(px);
  assign xs_c   = CH_W'(xs);
  assign y_c    = CH_W'(py);
  assign flat_c = CH_W'(frame_cnt);
  assign bar_m  = bar_mask(BAR_COLOURS[bar_q]);
  assign vis_c  = (px < X_VIS) && (py < Y_VIS);

  always_comb begin
    rgb_c = '0;
    if (vis_c) begin
      case (mode_q)
        MODE_BORDER: begin
          // Border test deliberately uses the unscrolled column.
          if (px == '0 || py == '0 || px == X_RIGHT || py == Y_BOT)
            rgb_c = '1;
          else if (xs_c[0] ^ y_c[0])
            rgb_c = {xs_c, y_c, {CH_W{1'b0}}};
        end
        MODE_BARS: rgb_c = {{CH_W{bar_m[2]}}, {CH_W{bar_m[1]}}, {CH_W{bar_m[0]}}};
        MODE_GRAD: rgb_c = {x_c, y_c, x_c ^ y_c};
        MODE_FLAT: rgb_c = {flat_c, flat_c, flat_c};
        default:   rgb_c = '0;
      endcase
    end
  end

  // First output stage; any further latency is added by the delay line.
  logic [PIX_W:0] stage1_q, out_q;

  always_ff @(posedge clk_p) begin
    if (rst_p) stage1_q <= '0;
    else       stage1_q <= {vis_c, rgb_c};
  end

  if (LATENCY > 1) begin : g_delay
    ppu_pipe_delay #(
      .WIDTH (PIX_W + 1),
      .DEPTH (LATENCY - 1)
    ) u_delay (
      .clk_p (clk_p),
      .rst_p (rst_p),
      .d     (stage1_q),
      .q     (out_q)
    );
  end else begin : g_direct
    assign out_q = stage1_q;
  end

  assign visible = out_q[PIX_W];
  assign rgb_p   = out_q[PIX_W-1:0];

endmodule
